// File: rtl/lbus_slave_router.sv
// -----------------------------------------------------------------------------
// lbus_slave_router
// Local-bus fan-out from the EBI-side CPU bus to P_SLV_NUM configuration
// slaves. The upper P_SEL_WIDTH address bits select a slave; that slave's
// strobe is driven and its wait/read-data handshake is relayed to the CPU.
// Adds out-of-range select errors, a sticky error flag with a saturating
// error counter, and interrupt aggregation.
//
// Optional feature macro: LBUS_TIMEOUT_EN
//   defined   -> 16-bit per-access timeout counter; abort with error after
//                P_TIMEOUT cycles in ACCESS without slave ready.
//   undefined -> ACCESS waits indefinitely for the slave.
//
// Ports
//   clk_cfg, rst_cfg          config clock, async active-high reset
//   m_addr/m_wdata            CPU address (MSBs = slave select) / write data
//   m_cs_n/m_oe_n/m_we_n      CPU chip select / read / write strobes
//   m_rdata, m_wait_n         registered read data, low = access in progress
//   m_int                     registered OR of unmasked slave interrupts
//   m_err, err_cnt, err_clr   sticky error flag, saturating count, clear pulse
//   s_addr/s_wdata            latched address / write data shared by slaves
//   s_rdata, s_wait_n         per-slave read data (k at [k*DW +: DW]) / ready
//   s_oe_n/s_we_n             per-slave strobes
//   s_int, int_mask           slave interrupts / 1 = masked
// -----------------------------------------------------------------------------
module lbus_slave_router #(
  parameter int unsigned P_BUS_ADDR_WIDTH = 12,
  parameter int unsigned P_BUS_DATA_WIDTH = 16,
  parameter int unsigned P_SLV_NUM        = 4,
  parameter int unsigned P_SEL_WIDTH      = 2,
  parameter int unsigned P_TIMEOUT        = 255
) (
  input  logic                                    clk_cfg,
  input  logic                                    rst_cfg,
  input  logic [P_SEL_WIDTH+P_BUS_ADDR_WIDTH-1:0] m_addr,
  input  logic [P_BUS_DATA_WIDTH-1:0]             m_wdata,
  output logic [P_BUS_DATA_WIDTH-1:0]             m_rdata,
  input  logic                                    m_cs_n,
  input  logic                                    m_oe_n,
  input  logic                                    m_we_n,
  output logic                                    m_wait_n,
  output logic                                    m_int,
  output logic                                    m_err,
  input  logic                                    err_clr,
  output logic [7:0]                              err_cnt,
  output logic [P_BUS_ADDR_WIDTH-1:0]             s_addr,
  output logic [P_BUS_DATA_WIDTH-1:0]             s_wdata,
  input  logic [P_SLV_NUM*P_BUS_DATA_WIDTH-1:0]   s_rdata,
  output logic [P_SLV_NUM-1:0]                    s_oe_n,
  output logic [P_SLV_NUM-1:0]                    s_we_n,
  input  logic [P_SLV_NUM-1:0]                    s_wait_n,
  input  logic [P_SLV_NUM-1:0]                    s_int,
  input  logic [P_SLV_NUM-1:0]                    int_mask
);

  localparam int unsigned AW = P_BUS_ADDR_WIDTH;
  localparam int unsigned DW = P_BUS_DATA_WIDTH;
  localparam int unsigned NS = P_SLV_NUM;
  localparam int unsigned SW = P_SEL_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_BADSEL, ST_DONE} state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  m_rdata_q, m_rdata_d;
  logic           m_wait_n_q, m_wait_n_d;
  logic           m_int_q, m_int_d;
  logic           m_err_q, m_err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic [AW-1:0]  s_addr_q, s_addr_d;
  logic [DW-1:0]  s_wdata_q, s_wdata_d;
  logic [NS-1:0]  s_oe_n_q, s_oe_n_d;
  logic [NS-1:0]  s_we_n_q, s_we_n_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           rd_q, rd_d;

  logic           req_c;
  logic [SW-1:0]  sel_in_c;
  logic           sel_ok_c;
  logic [NS-1:0]  sel_oh_c;
  logic [NS-1:0]  wait_sh_c;
  logic [NS*DW-1:0] rdata_sh_c;
  logic           slv_rdy_c;
  logic           tmo_hit_c;
  logic           err_set_c;

  // Request: chip select with exactly one of read/write strobes active
  assign req_c     = ~m_cs_n & (m_oe_n ^ m_we_n);
  assign sel_in_c  = m_addr[AW+SW-1:AW];
  assign sel_ok_c  = (32'(sel_in_c) < NS);
  assign sel_oh_c  = NS'(1) << sel_in_c;

  // Shift-based slave mux keeps out-of-range select widths lint-safe
  assign wait_sh_c  = s_wait_n >> sel_q;
  assign slv_rdy_c  = wait_sh_c[0];
  assign rdata_sh_c = s_rdata >> (32'(sel_q) * DW);

`ifdef LBUS_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Counts ACCESS cycles; cleared whenever not in ACCESS
  always_comb begin
    tmo_d = 16'd0;
    if (state_q == ST_ACCESS) tmo_d = tmo_q + 16'd1;
  end

  always_ff @(posedge clk_cfg or posedge rst_cfg) begin
    if (rst_cfg) tmo_q <= 16'd0;
    else         tmo_q <= tmo_d;
  end

  assign tmo_hit_c = (tmo_q == 16'(P_TIMEOUT));
`else
  logic unused_tmo_c;
  assign unused_tmo_c = ^16'(P_TIMEOUT);
  assign tmo_hit_c    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_cfg or posedge rst_cfg) begin
    if (rst_cfg) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; CPU abort takes priority over completion and timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_c) state_d = sel_ok_c ? ST_ACCESS : ST_BADSEL;
      ST_ACCESS: begin
        if (m_cs_n)                      state_d = ST_IDLE;
        else if (slv_rdy_c || tmo_hit_c) state_d = ST_DONE;
      end
      ST_BADSEL: state_d = ST_DONE;
      ST_DONE:   if (m_cs_n) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    m_rdata_d  = m_rdata_q;
    m_wait_n_d = m_wait_n_q;
    m_err_d    = m_err_q;
    err_cnt_d  = err_cnt_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_oe_n_d   = s_oe_n_q;
    s_we_n_d   = s_we_n_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    err_set_c  = 1'b0;
    m_int_d    = |(s_int & ~int_mask);

    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          s_addr_d   = m_addr[AW-1:0];
          s_wdata_d  = m_wdata;
          sel_d      = sel_in_c;
          rd_d       = ~m_oe_n;
          m_wait_n_d = 1'b0;
          if (sel_ok_c) begin
            if (!m_oe_n) s_oe_n_d = ~sel_oh_c;
            else         s_we_n_d = ~sel_oh_c;
          end
        end
      end
      ST_ACCESS: begin
        if (m_cs_n) begin
          s_oe_n_d   = '1;
          s_we_n_d   = '1;
          m_wait_n_d = 1'b1;
        end else if (slv_rdy_c) begin
          s_oe_n_d   = '1;
          s_we_n_d   = '1;
          m_wait_n_d = 1'b1;
          if (rd_q) m_rdata_d = rdata_sh_c[DW-1:0];
        end else if (tmo_hit_c) begin
          s_oe_n_d   = '1;
          s_we_n_d   = '1;
          m_wait_n_d = 1'b1;
          m_rdata_d  = '1;
          err_set_c  = 1'b1;
        end
      end
      ST_BADSEL: begin
        m_rdata_d  = '1;
        m_wait_n_d = 1'b1;
        err_set_c  = 1'b1;
      end
      default: ;
    endcase

    // Clear wins over a coincident new error
    if (err_clr) begin
      m_err_d   = 1'b0;
      err_cnt_d = 8'd0;
    end else if (err_set_c) begin
      m_err_d   = 1'b1;
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end
  end

  // Datapath / output registers
  always_ff @(posedge clk_cfg or posedge rst_cfg) begin
    if (rst_cfg) begin
      m_rdata_q  <= '0;
      m_wait_n_q <= 1'b1;
      m_int_q    <= 1'b0;
      m_err_q    <= 1'b0;
      err_cnt_q  <= 8'd0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_oe_n_q   <= '1;
      s_we_n_q   <= '1;
      sel_q      <= '0;
      rd_q       <= 1'b0;
    end else begin
      m_rdata_q  <= m_rdata_d;
      m_wait_n_q <= m_wait_n_d;
      m_int_q    <= m_int_d;
      m_err_q    <= m_err_d;
      err_cnt_q  <= err_cnt_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_oe_n_q   <= s_oe_n_d;
      s_we_n_q   <= s_we_n_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
    end
  end

  assign m_rdata  = m_rdata_q;
  assign m_wait_n = m_wait_n_q;
  assign m_int    = m_int_q;
  assign m_err    = m_err_q;
  assign err_cnt  = err_cnt_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_oe_n   = s_oe_n_q;
  assign s_we_n   = s_we_n_q;

endmodule

// File: tb/tb_lbus_slave_router.sv
// -----------------------------------------------------------------------------
// tb_lbus_slave_router
// Directed plus randomized accesses against a transaction-level model: each
// access's expected completion cycle, strobe pattern, read data and error
// bookkeeping are computed from the bus rules, then checked cycle by cycle.
// Configured with 3 slaves and a 2-bit select so select 3 is out of range.
// -----------------------------------------------------------------------------
module tb_lbus_slave_router;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 16;
  localparam int unsigned NS  = 3;
  localparam int unsigned SW  = 2;
  localparam int unsigned TMO = 8;

  logic                clk_cfg;
  logic                rst_cfg;
  logic [SW+AW-1:0]    m_addr;
  logic [DW-1:0]       m_wdata;
  logic [DW-1:0]       m_rdata;
  logic                m_cs_n, m_oe_n, m_we_n;
  logic                m_wait_n, m_int, m_err, err_clr;
  logic [7:0]          err_cnt;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdata;
  logic [NS*DW-1:0]    s_rdata;
  logic [NS-1:0]       s_oe_n, s_we_n, s_wait_n, s_int, int_mask;

  lbus_slave_router #(
    .P_BUS_ADDR_WIDTH(AW), .P_BUS_DATA_WIDTH(DW), .P_SLV_NUM(NS),
    .P_SEL_WIDTH(SW), .P_TIMEOUT(TMO)
  ) dut (
    .clk_cfg(clk_cfg), .rst_cfg(rst_cfg), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_cs_n(m_cs_n), .m_oe_n(m_oe_n), .m_we_n(m_we_n),
    .m_wait_n(m_wait_n), .m_int(m_int), .m_err(m_err), .err_clr(err_clr),
    .err_cnt(err_cnt), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .s_oe_n(s_oe_n), .s_we_n(s_we_n), .s_wait_n(s_wait_n), .s_int(s_int),
    .int_mask(int_mask)
  );

  initial clk_cfg = 1'b0;
  always #5 clk_cfg = ~clk_cfg;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  int            exp_cnt;
  logic [DW-1:0] slv_data [NS];
  logic [NS-1:0] all1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_rdata"}, m_rdata, exp_rdata);
    check({tag, "_err"}, m_err, exp_err);
    check({tag, "_cnt"}, err_cnt, 32'(exp_cnt));
  endtask

  // One CPU access. w = cycles the selected slave holds wait_n low after its
  // strobe appears; abort_at > 0 lifts m_cs_n before that ACCESS edge;
  // clr_end pulses err_clr on the completing edge. Starts and ends at negedge.
  task automatic do_access(input int sel, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int w, input int abort_at,
                           input bit clr_end);
    bit            bad, timed_out, active;
    int            done_k, end_k;
    logic [NS-1:0] oh, strobe_exp;
    bad = (sel >= int'(NS));
    timed_out = 1'b0;
    done_k = bad ? 1 : w + 1;
`ifdef LBUS_TIMEOUT_EN
    if (!bad && w > int'(TMO)) begin
      timed_out = 1'b1;
      done_k = TMO + 1;
    end
`endif
    end_k = (abort_at > 0) ? abort_at : done_k;
    oh = '0;
    if (!bad) oh[sel] = 1'b1;
    strobe_exp = ~oh;
    for (int i = 0; i < int'(NS); i++) begin
      slv_data[i] = DW'($urandom);
      s_rdata[i*DW +: DW] = slv_data[i];
    end
    m_addr  = {SW'(sel), addr};
    m_wdata = wd;
    m_oe_n  = wr;
    m_we_n  = !wr;
    m_cs_n  = 1'b0;
    for (int k = 0; k <= end_k; k++) begin
      s_wait_n = NS'($urandom);
      if (!bad) s_wait_n[sel] = (k >= w + 1);
      if (abort_at > 0 && k == abort_at) m_cs_n = 1'b1;
      if (clr_end && k == done_k) err_clr = 1'b1;
      @(negedge clk_cfg);
      err_clr = 1'b0;
      active = (k < end_k);
      check("wait_n", m_wait_n, 32'(!active));
      check("oe_n", s_oe_n, (active && !wr) ? strobe_exp : all1);
      check("we_n", s_we_n, (active && wr) ? strobe_exp : all1);
    end
    if (abort_at == 0) begin
      if (clr_end) begin
        exp_err = 1'b0;
        exp_cnt = 0;
      end
      if (bad || timed_out) begin
        exp_rdata = '1;
        if (!clr_end) begin
          exp_err = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end else if (!wr) begin
        exp_rdata = slv_data[sel];
      end
    end
    check_status("acc");
    check("s_addr", s_addr, 32'(addr));
    check("s_wdata", s_wdata, 32'(wd));
    if (abort_at == 0) begin
      // CPU still holds chip select: result must be held
      @(negedge clk_cfg);
      check("done_wait_n", m_wait_n, 1);
      check("done_rdata", m_rdata, exp_rdata);
      m_cs_n = 1'b1;
    end
    m_oe_n = 1'b1;
    m_we_n = 1'b1;
    @(negedge clk_cfg);
    check("idle_wait_n", m_wait_n, 1);
    check("idle_oe_n", s_oe_n, all1);
    check("idle_we_n", s_we_n, all1);
  endtask

  logic [NS-1:0] pi, pm;
  int            r_sel, r_w, r_ab, r_max;
  bit            r_wr, r_clr;

  initial begin
    all1 = '1;
    rst_cfg = 1'b1;
    m_addr = '0; m_wdata = '0; m_cs_n = 1'b1; m_oe_n = 1'b1; m_we_n = 1'b1;
    err_clr = 1'b0; s_rdata = '0; s_wait_n = '1; s_int = '0; int_mask = '0;
    exp_rdata = '0; exp_err = 1'b0; exp_cnt = 0;
    repeat (3) @(negedge clk_cfg);
    check("rst_wait_n", m_wait_n, 1);
    check("rst_oe_n", s_oe_n, all1);
    check("rst_we_n", s_we_n, all1);
    check("rst_int", m_int, 0);
    check("rst_saddr", s_addr, 0);
    check("rst_swdata", s_wdata, 0);
    check_status("rst");
    rst_cfg = 1'b0;
    @(negedge clk_cfg);

    // Read, slave 0 waits 3 cycles
    do_access(0, 1'b0, 12'h800, 16'h0000, 3, 0, 1'b0);
    // Zero-wait write to slave 2
    do_access(2, 1'b1, 12'h010, 16'hA5A5, 0, 0, 1'b0);
    // Out-of-range select
    do_access(3, 1'b0, 12'h123, 16'h0000, 0, 0, 1'b0);
`ifdef LBUS_TIMEOUT_EN
    // Stuck slave 1: aborted by timeout
    do_access(1, 1'b0, 12'h0F0, 16'h0000, 40, 0, 1'b0);
`else
    // Stuck slave 1: waits well past P_TIMEOUT, then CPU gives up
    do_access(1, 1'b0, 12'h0F0, 16'h0000, 40, 30, 1'b0);
`endif
    // Software clear of the error state
    err_clr = 1'b1;
    @(negedge clk_cfg);
    err_clr = 1'b0;
    exp_err = 1'b0;
    exp_cnt = 0;
    check_status("clr");

    // CPU abort two cycles into ACCESS, then a normal read
    do_access(0, 1'b0, 12'h321, 16'h0000, 6, 2, 1'b0);
    do_access(0, 1'b0, 12'h322, 16'h0000, 1, 0, 1'b0);

    // Both strobes low is not a request
    m_addr = {2'd1, 12'h004}; m_cs_n = 1'b0; m_oe_n = 1'b0; m_we_n = 1'b0;
    repeat (2) @(negedge clk_cfg);
    check("both_wait_n", m_wait_n, 1);
    check("both_oe_n", s_oe_n, all1);
    check("both_we_n", s_we_n, all1);
    m_cs_n = 1'b1; m_oe_n = 1'b1; m_we_n = 1'b1;
    @(negedge clk_cfg);

    // Error coincident with err_clr is dropped
    do_access(3, 1'b0, 12'h000, 16'h0000, 0, 0, 1'b0);
    do_access(3, 1'b1, 12'h001, 16'h5A5A, 0, 0, 1'b1);

    // Interrupt aggregation
    s_int = 3'b101; int_mask = 3'b001;
    @(negedge clk_cfg);
    check("int_unmasked", m_int, 1);
    int_mask = 3'b101;
    @(negedge clk_cfg);
    check("int_masked", m_int, 0);
    for (int i = 0; i < 20; i++) begin
      pi = NS'($urandom);
      pm = NS'($urandom);
      s_int = pi;
      int_mask = pm;
      @(negedge clk_cfg);
      check("int_rand", m_int, 32'(|(pi & ~pm)));
    end
    s_int = '0; int_mask = '0;

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      r_sel = $urandom_range(0, 3);
      r_wr  = 1'($urandom);
`ifdef LBUS_TIMEOUT_EN
      r_w = $urandom_range(0, TMO + 4);
`else
      r_w = $urandom_range(0, 6);
`endif
      r_max = (r_w < int'(TMO)) ? r_w : int'(TMO);
      r_ab = 0;
      if (r_sel < int'(NS) && r_max >= 1 && $urandom_range(0, 4) == 0)
        r_ab = $urandom_range(1, r_max);
      r_clr = (r_ab == 0) && ($urandom_range(0, 7) == 0);
      do_access(r_sel, r_wr, AW'($urandom), DW'($urandom), r_w, r_ab, r_clr);
    end

    // Error counter saturation
    for (int i = 0; i < 258; i++)
      do_access(3, 1'b0, AW'(i), 16'h0000, 0, 0, 1'b0);
    check("sat_cnt", err_cnt, 255);

    // Reset in the middle of an access
    s_wait_n = '0;
    m_addr = {2'd1, 12'h055}; m_oe_n = 1'b0; m_we_n = 1'b1; m_cs_n = 1'b0;
    repeat (3) @(negedge clk_cfg);
    check("pre_rst_oe_n", s_oe_n, 32'(3'b101));
    check("pre_rst_wait_n", m_wait_n, 0);
    #2 rst_cfg = 1'b1;
    #1;
    exp_rdata = '0; exp_err = 1'b0; exp_cnt = 0;
    check("mid_rst_wait_n", m_wait_n, 1);
    check("mid_rst_oe_n", s_oe_n, all1);
    check("mid_rst_saddr", s_addr, 0);
    check_status("mid_rst");
    @(negedge clk_cfg);
    rst_cfg = 1'b0; m_cs_n = 1'b1; m_oe_n = 1'b1; s_wait_n = '1;
    @(negedge clk_cfg);
    check("post_rst_wait_n", m_wait_n, 1);
    do_access(1, 1'b0, 12'h777, 16'h0000, 2, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
